alu_sequencer: RTL and testbench

- Control-side counterpart of the ALU datapath block: generates the outctl, loadctl, alt and calcfn controls that the datapath consumes.
- Accepts one ALU opcode at a time over a valid/ready handshake and expands it into 1–2 micro-steps.
- Raises a one-cycle done pulse when the last step has been issued.
- Sits between instruction decode and the ALU block. The only interaction with the main bus is via ext_oe and ext_load strobes to the external bus source and sink.

---
 rtl/alu_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Expands one ALU opcode into 1-2 registered control steps for the ALU datapath.
// Takes one opcode per valid/ready handshake; no back-to-back accepts.
module alu_sequencer #(
  parameter logic [2:0] NONE_SEL = 3'd7,
  parameter int         OP_W     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  input  logic [OP_W-1:0] cmd_op,
  output logic            cmd_ready,
  output logic [2:0]      outctl,
  output logic [2:0]      loadctl,
  output logic            alt,
  output logic            calcfn,
  output logic            ext_oe,
  output logic            ext_load,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, S0, S1} state_t;

  typedef struct packed {
    logic [2:0] outctl;
    logic [2:0] loadctl;
    logic       alt;
    logic       calcfn;
    logic       ext_oe;
    logic       ext_load;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{outctl: NONE_SEL, loadctl: NONE_SEL, alt: 1'b0,
                                calcfn: 1'b1, ext_oe: 1'b0, ext_load: 1'b0};

  state_t          state_q;
  ctl_t            ctl_q;
  logic [OP_W-1:0] op_q;
  logic            ready_q;
  logic            done_q;
  logic            err_q;

  function automatic logic is_two_step(input logic [OP_W-1:0] op);
    return (op == OP_W'(8)) || (op == OP_W'(9)) || (op == OP_W'(10));
  endfunction

  // Fields not named for an opcode/step stay at their idle value.
  function automatic ctl_t step_ctl(input logic [OP_W-1:0] op, input logic second);
    ctl_t c;
    c = CTL_IDLE;
    if (!second) begin
      case (op)
        OP_W'(1):  begin c.outctl = 3'd1; c.loadctl = 3'd0; end
        OP_W'(2):  begin c.outctl = 3'd0; c.loadctl = 3'd1; end
        OP_W'(3):  begin c.outctl = 3'd2; c.loadctl = 3'd0; c.calcfn = 1'b0; end
        OP_W'(4):  begin c.outctl = 3'd2; c.loadctl = 3'd0; c.alt = 1'b1; c.calcfn = 1'b0; end
        OP_W'(5):  begin c.outctl = 3'd2; c.alt = 1'b1; c.calcfn = 1'b0; end
        OP_W'(6):  begin c.ext_oe = 1'b1; c.loadctl = 3'd0; end
        OP_W'(7), OP_W'(8), OP_W'(9), OP_W'(10):
                   begin c.ext_oe = 1'b1; c.loadctl = 3'd1; end
        OP_W'(11): begin c.outctl = 3'd0; c.ext_load = 1'b1; end
        OP_W'(12): begin c.outctl = 3'd1; c.ext_load = 1'b1; end
        default:   c = CTL_IDLE;
      endcase
    end else begin
      case (op)
        OP_W'(8):  begin c.outctl = 3'd2; c.loadctl = 3'd0; c.calcfn = 1'b0; end
        OP_W'(9):  begin c.outctl = 3'd2; c.loadctl = 3'd0; c.alt = 1'b1; c.calcfn = 1'b0; end
        OP_W'(10): begin c.outctl = 3'd2; c.alt = 1'b1; c.calcfn = 1'b0; end
        default:   c = CTL_IDLE;
      endcase
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctl_q   <= CTL_IDLE;
      op_q    <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          ctl_q  <= CTL_IDLE;
          if (cmd_valid && ready_q) begin
            state_q <= S0;
            op_q    <= cmd_op;
            err_q   <= (cmd_op > OP_W'(12));
            ctl_q   <= step_ctl(cmd_op, 1'b0);
            done_q  <= !is_two_step(cmd_op);
            ready_q <= 1'b0;
          end
        end
        S0: begin
          if (is_two_step(op_q)) begin
            state_q <= S1;
            ctl_q   <= step_ctl(op_q, 1'b1);
            done_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            ctl_q   <= CTL_IDLE;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ctl_q   <= CTL_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign outctl    = ctl_q.outctl;
  assign loadctl   = ctl_q.loadctl;
  assign alt       = ctl_q.alt;
  assign calcfn    = ctl_q.calcfn;
  assign ext_oe    = ctl_q.ext_oe;
  assign ext_load  = ctl_q.ext_load;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer with hand-computed control values.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [3:0] cmd_op;
  logic       cmd_ready;
  logic [2:0] outctl;
  logic [2:0] loadctl;
  logic       alt;
  logic       calcfn;
  logic       ext_oe;
  logic       ext_load;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .outctl(outctl), .loadctl(loadctl), .alt(alt),
    .calcfn(calcfn), .ext_oe(ext_oe), .ext_load(ext_load), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] oc, input logic [2:0] lc,
                         input logic a, input logic cf, input logic eo, input logic el,
                         input logic dn, input logic rdy, input logic er);
    chk({tag, ".outctl"},   8'(outctl),    8'(oc));
    chk({tag, ".loadctl"},  8'(loadctl),   8'(lc));
    chk({tag, ".alt"},      8'(alt),       8'(a));
    chk({tag, ".calcfn"},   8'(calcfn),    8'(cf));
    chk({tag, ".ext_oe"},   8'(ext_oe),    8'(eo));
    chk({tag, ".ext_load"}, 8'(ext_load),  8'(el));
    chk({tag, ".done"},     8'(done),      8'(dn));
    chk({tag, ".ready"},    8'(cmd_ready), 8'(rdy));
    chk({tag, ".err"},      8'(err),       8'(er));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an opcode and let it be accepted on the next edge.
  task automatic issue(input logic [3:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Bus exclusivity must hold on every cycle once reset has been applied.
  always @(negedge clk) begin
    if (mon_en) chk("excl", 8'(ext_oe && (outctl != 3'd7)), 8'd0);
  end

  // {op, outctl, loadctl, alt, calcfn, ext_oe, ext_load, err}
  localparam logic [14:0] VEC [11] = '{
    {4'h3, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
    {4'hE, 3'd7, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
    {4'h0, 3'd7, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
    {4'h1, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
    {4'h2, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
    {4'h4, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
    {4'h5, 3'd2, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
    {4'h6, 3'd7, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
    {4'h7, 3'd7, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
    {4'hB, 3'd0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
    {4'hC, 3'd1, 3'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}
  };

  initial begin
    logic [14:0] v;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0;
    tick(); tick();
    rst = 1'b0;
    mon_en = 1'b1;
    chk_all("reset", 3'd7, 3'd7, 0, 1, 0, 0, 0, 1, 0);

    // One-step opcodes: step then idle with err held.
    for (int i = 0; i < 11; i++) begin
      v = VEC[i];
      issue(v[14:11]);
      chk_all($sformatf("op%0h.s0", v[14:11]), v[10:8], v[7:5], v[4], v[3], v[2], v[1], 1, 0, v[0]);
      tick();
      chk_all($sformatf("op%0h.idle", v[14:11]), 3'd7, 3'd7, 0, 1, 0, 0, 0, 1, v[0]);
    end

    // SUBI
    issue(4'h9);
    chk_all("subi.s0", 3'd7, 3'd1, 0, 1, 1, 0, 0, 0, 0);
    tick();
    chk_all("subi.s1", 3'd2, 3'd0, 1, 0, 0, 0, 1, 0, 0);
    tick();
    chk_all("subi.idle", 3'd7, 3'd7, 0, 1, 0, 0, 0, 1, 0);

    // CMPI
    issue(4'hA);
    chk_all("cmpi.s0", 3'd7, 3'd1, 0, 1, 1, 0, 0, 0, 0);
    tick();
    chk_all("cmpi.s1", 3'd2, 3'd7, 1, 0, 0, 0, 1, 0, 0);
    tick();
    chk_all("cmpi.idle", 3'd7, 3'd7, 0, 1, 0, 0, 0, 1, 0);

    // Busy ignore: ADD held valid throughout ADDI, accepted only once idle.
    issue(4'h8);
    cmd_valid = 1'b1; cmd_op = 4'h3;
    chk_all("busy.s0", 3'd7, 3'd1, 0, 1, 1, 0, 0, 0, 0);
    tick();
    chk_all("busy.s1", 3'd2, 3'd0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    chk_all("busy.idle", 3'd7, 3'd7, 0, 1, 0, 0, 0, 1, 0);
    tick();
    cmd_valid = 1'b0;
    chk_all("busy.add", 3'd2, 3'd0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    chk_all("busy.end", 3'd7, 3'd7, 0, 1, 0, 0, 0, 1, 0);

    // Reset during S0 of ADDI: abandoned, no done.
    issue(4'h8);
    chk_all("rmid.s0", 3'd7, 3'd1, 0, 1, 1, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk_all("rmid.rst", 3'd7, 3'd7, 0, 1, 0, 0, 0, 1, 0);
    rst = 1'b0;
    tick();
    chk_all("rmid.after", 3'd7, 3'd7, 0, 1, 0, 0, 0, 1, 0);

    // Reset wins over a simultaneous request (illegal op would set err).
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 4'hF;
    tick();
    rst = 1'b0; cmd_valid = 1'b0;
    chk_all("rstvld", 3'd7, 3'd7, 0, 1, 0, 0, 0, 1, 0);
    tick();
    chk_all("rstvld.next", 3'd7, 3'd7, 0, 1, 0, 0, 0, 1, 0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
